// File: rtl/md_unit.sv
// Purpose : iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO registers, plus MTHI/MTLO writes.
// Latency : WIDTH edges from the start edge to the HI/LO write; done pulses for one cycle on that write.
// Backpr. : no handshake; busy is high while an op runs and stalls dependent instructions. start is ignored while busy.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, op, x, y     launch an op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU) with operands x/y
//   cancel              pipeline flush, aborts a running op without touching HI/LO
//   hi_we, lo_we, wdata MTHI/MTLO writes, honoured only while idle and not starting
//   busy, done          op in progress / one-cycle completion pulse
//   hi, lo              architectural HI/LO registers
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    count_q;
  logic             is_div_q;   // op[1] of the running op
  logic             neg_q_q;    // negate product / quotient at the end
  logic             neg_r_q;    // negate remainder at the end
  logic             dz_q;       // divisor was zero
  logic [WIDTH-1:0] x_q;        // raw dividend, returned as HI on divide by zero
  logic [WIDTH-1:0] mcand_q;    // |multiplicand| or |divisor|
  logic [WIDTH-1:0] whi_q;      // partial product high half / partial remainder
  logic [WIDTH-1:0] wlo_q;      // multiplier bits / dividend bits shifting into quotient

  // Operand conditioning at launch
  logic             is_signed;
  logic [WIDTH-1:0] abs_x, abs_y;

  always_comb begin
    is_signed = ~op[0];
    abs_x     = (is_signed && x[WIDTH-1]) ? (~x + 1'b1) : x;
    abs_y     = (is_signed && y[WIDTH-1]) ? (~y + 1'b1) : y;
  end

  // Control
  logic accept;
  logic last;

  always_comb begin
    accept = (state_q == IDLE) && start && !cancel;
    last   = (state_q == RUN) && !cancel && (count_q == CW'(1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (cancel || count_q == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration of each algorithm.
  // Multiply: add multiplicand if the current multiplier bit is set, then shift
  // the {carry, whi, wlo} triple right; multiplier bits retire out of wlo while
  // product bits enter at its top.
  // Divide: shift the next dividend bit into the remainder and keep the trial
  // subtraction if it does not go negative. The remainder stays below the
  // divisor, so when the trial fails the shifted value still fits WIDTH bits.
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  always_comb begin
    msum    = {1'b0, whi_q} + (wlo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    shifted = {whi_q, wlo_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, mcand_q};
    fits    = ~diff[WIDTH+1];
    if (is_div_q) begin
      nxt_hi = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      nxt_lo = {wlo_q[WIDTH-2:0], fits};
    end else begin
      nxt_hi = msum[WIDTH:1];
      nxt_lo = {msum[0], wlo_q[WIDTH-1:1]};
    end
  end

  // Sign correction of the final iteration's magnitudes
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod = {nxt_hi, nxt_lo};
    if (neg_q_q) prod = ~prod + 1'b1;
    if (!is_div_q) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (dz_q) begin
      res_hi = x_q;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = neg_r_q ? (~nxt_hi + 1'b1) : nxt_hi;
      res_lo = neg_q_q ? (~nxt_lo + 1'b1) : nxt_lo;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and architectural registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      x_q      <= '0;
      mcand_q  <= '0;
      whi_q    <= '0;
      wlo_q    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        count_q  <= CW'(WIDTH);
        is_div_q <= op[1];
        neg_q_q  <= is_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
        neg_r_q  <= is_signed && op[1] && x[WIDTH-1];
        dz_q     <= (y == '0);
        x_q      <= x;
        whi_q    <= '0;
        if (op[1]) begin
          wlo_q   <= abs_x;
          mcand_q <= abs_y;
        end else begin
          wlo_q   <= abs_y;
          mcand_q <= abs_x;
        end
      end else if (state_q == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end else if (!cancel) begin
        count_q <= count_q - 1'b1;
        whi_q   <= nxt_hi;
        wlo_q   <= nxt_lo;
        if (last) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end
  end

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n, start, cancel, hi_we, lo_we;
  logic [1:0]    op;
  logic [W-1:0]  x, y, wdata;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int tests  = 0;
  int errors = 0;

  md_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .x(x), .y(y),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: architectural result from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Launch an op and observe the following W+4 cycles (k=0 is the cycle after the start edge).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output int ndone, output int dpos,
                        output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    start = 1'b1; op = o; x = a; y = b;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; ndone = 0; dpos = -1;
    for (int k = 0; k < W + 4; k++) begin
      if (busy) nbusy++;
      if (done) begin ndone++; dpos = k; end
      @(negedge clk);
    end
    h = hi; l = lo;
  endtask

  task automatic preload(input logic [31:0] v);
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = v;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; x = '0; y = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_mult();
    logic [1:0]  ops [2] = '{2'b00, 2'b01};
    logic [31:0] xs  [2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [31:0] ys  [2] = '{32'h5, 32'hFFFF_FFFF};
    logic [31:0] eh  [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] el  [2] = '{32'hFFFF_FFF1, 32'h0000_0001};
    int nb, nd, dp;
    logic [31:0] h, l;
    for (int i = 0; i < 2; i++) begin
      run_op(ops[i], xs[i], ys[i], nb, nd, dp, h, l);
      tests++;
      if (nb !== W || nd !== 1 || dp !== W) begin
        errors++;
        $display("FAIL mult%0d_timing busy_cycles=%0d done_cnt=%0d done_at=%0d want %0d 1 %0d", i, nb, nd, dp, W, W);
      end
      tests++;
      if (h !== eh[i] || l !== el[i]) begin
        errors++;
        $display("FAIL mult%0d_result hi=%h lo=%h want %h %h", i, h, l, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [1:0]  ops [3] = '{2'b10, 2'b10, 2'b11};
    logic [31:0] xs  [3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] ys  [3] = '{32'h2, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] eh  [3] = '{32'hFFFF_FFFF, 32'h0, 32'h1234_5678};
    logic [31:0] el  [3] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    int nb, nd, dp;
    logic [31:0] h, l;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], xs[i], ys[i], nb, nd, dp, h, l);
      tests++;
      if (nb !== W || nd !== 1 || dp !== W) begin
        errors++;
        $display("FAIL div%0d_timing busy_cycles=%0d done_cnt=%0d done_at=%0d want %0d 1 %0d", i, nb, nd, dp, W, W);
      end
      tests++;
      if (h !== eh[i] || l !== el[i]) begin
        errors++;
        $display("FAIL div%0d_result hi=%h lo=%h want %h %h", i, h, l, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_random();
    int nb, nd, dp;
    logic [31:0] a, b, h, l;
    logic [1:0]  o;
    logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      e = model(o, a, b);
      run_op(o, a, b, nb, nd, dp, h, l);
      tests++;
      if (nb !== W || nd !== 1 || dp !== W) begin
        errors++;
        $display("FAIL rand%0d_timing busy_cycles=%0d done_cnt=%0d done_at=%0d", i, nb, nd, dp);
      end
      tests++;
      if (h !== e[63:32] || l !== e[31:0]) begin
        errors++;
        $display("FAIL rand%0d op=%0d x=%h y=%h hi=%h lo=%h want %h %h", i, o, a, b, h, l, e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    preload(32'hAAAA_AAAA);
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1357_9BDF;
    @(negedge clk);
    hi_we = 1'b0;
    tests++;
    if (hi !== 32'h1357_9BDF || lo !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL mthi_only hi=%h lo=%h want 13579bdf aaaaaaaa", hi, lo);
    end
    // cancel in IDLE still lets MTLO through
    cancel = 1'b1; lo_we = 1'b1; wdata = 32'h0246_8ACE;
    @(negedge clk);
    cancel = 1'b0; lo_we = 1'b0;
    tests++;
    if (lo !== 32'h0246_8ACE || hi !== 32'h1357_9BDF || busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_cancel hi=%h lo=%h busy=%b want 13579bdf 02468ace 0", hi, lo, busy);
    end
  endtask

  task automatic test_start_wins();
    int nb, nd, dp;
    logic [31:0] h0, l0;
    preload(32'h1111_2222);
    @(negedge clk);
    start = 1'b1; op = 2'b01; x = 32'd6; y = 32'd7; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    h0 = hi; l0 = lo;
    tests++;
    if (busy !== 1'b1 || h0 !== 32'h1111_2222 || l0 !== 32'h1111_2222) begin
      errors++;
      $display("FAIL start_wins busy=%b hi=%h lo=%h want 1 11112222 11112222", busy, h0, l0);
    end
    nb = 0; nd = 0; dp = -1;
    for (int k = 0; k < W + 4; k++) begin
      if (busy) nb++;
      if (done) begin nd++; dp = k; end
      @(negedge clk);
    end
    tests++;
    if (nb !== W || nd !== 1 || hi !== 32'h0 || lo !== 32'd42) begin
      errors++;
      $display("FAIL start_wins_result busy_cycles=%0d done_cnt=%0d hi=%h lo=%h want %0d 1 0 2a", nb, nd, hi, lo, W);
    end
  endtask

  task automatic test_cancel();
    int nd;
    preload(32'hAAAA_AAAA);
    @(negedge clk);
    cancel = 1'b1; start = 1'b1; op = 2'b11; x = 32'd100; y = 32'd7;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_blocks_start busy=%b want 0", busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_busy busy=%b want 0", busy);
    end
    nd = 0;
    for (int k = 0; k < W + 4; k++) begin
      if (done || busy) nd++;
      @(negedge clk);
    end
    tests++;
    if (nd !== 0 || hi !== 32'hAAAA_AAAA || lo !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL cancel_after done_or_busy=%0d hi=%h lo=%h want 0 aaaaaaaa aaaaaaaa", nd, hi, lo);
    end
  endtask

  task automatic test_start_ignored();
    int nb, nd;
    @(negedge clk);
    start = 1'b1; op = 2'b01; x = 32'd3; y = 32'd4;
    @(negedge clk);
    start = 1'b0;
    nb = 0; nd = 0;
    for (int k = 0; k < W + 4; k++) begin
      if (k == 5) begin start = 1'b1; op = 2'b10; x = 32'd100; y = 32'd7; end
      if (k == 6) start = 1'b0;
      if (busy) nb++;
      if (done) nd++;
      @(negedge clk);
    end
    tests++;
    if (nb !== W || nd !== 1 || hi !== 32'h0 || lo !== 32'd12) begin
      errors++;
      $display("FAIL start_ignored busy_cycles=%0d done_cnt=%0d hi=%h lo=%h want %0d 1 0 c", nb, nd, hi, lo, W);
    end
  endtask

  task automatic test_back_to_back();
    int nb, nd, dp, guard;
    logic [63:0] e;
    e = model(2'b10, 32'hFFFF_FF9C, 32'd7);
    @(negedge clk);
    start = 1'b1; op = 2'b00; x = 32'd9; y = 32'hFFFF_FFFE;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < W + 8) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (done !== 1'b1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEE) begin
      errors++;
      $display("FAIL b2b_first done=%b hi=%h lo=%h want 1 ffffffff ffffffee", done, hi, lo);
    end
    start = 1'b1; op = 2'b10; x = 32'hFFFF_FF9C; y = 32'd7;
    @(negedge clk);
    start = 1'b0;
    nb = 0; nd = 0; dp = -1;
    for (int k = 0; k < W + 4; k++) begin
      if (busy) nb++;
      if (done) begin nd++; dp = k; end
      @(negedge clk);
    end
    tests++;
    if (nb !== W || nd !== 1 || dp !== W || hi !== e[63:32] || lo !== e[31:0]) begin
      errors++;
      $display("FAIL b2b_second busy_cycles=%0d done_cnt=%0d done_at=%0d hi=%h lo=%h want %0d 1 %0d %h %h",
               nb, nd, dp, hi, lo, W, W, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_reset_mid_run();
    preload(32'h7777_8888);
    @(negedge clk);
    start = 1'b1; op = 2'b00; x = 32'd11; y = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_run busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    repeat (W + 2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_stays_idle busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_start_wins();
    test_cancel();
    test_start_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
